ldpc_decoder_scheduler: RTL and testbench

- Sits between the LDPC frame synchronizer and a bank of NUM_DEC LDPC decoder cores.
- Detects each framed codeword, assigns it to a free decoder, and streams its hard bits into that decoder.
- Retires decoded codewords to the downstream output mux in arrival order.
- Drives ldpcReady back to the framer so frame lock is only declared when decoder capacity exists.

---
 rtl/ldpc_decoder_scheduler_pkg.sv | 45 ++++
 rtl/ldpc_retire_fifo.sv | 60 ++++++
 rtl/ldpc_decoder_scheduler.sv | 256 +++++++++++++++++++++++++
 tb/tb_ldpc_decoder_scheduler.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_decoder_scheduler_pkg.sv
// LDPC decoder scheduler shared definitions.
// Rate codes, codeword lengths and slot/load state encodings.
package ldpc_decoder_scheduler_pkg;

  localparam logic [1:0] LDPC_RATE_1_2 = 2'd0;
  localparam logic [1:0] LDPC_RATE_2_3 = 2'd1;
  localparam logic [1:0] LDPC_RATE_4_5 = 2'd2;

  localparam int CW_LEN_W = 14;

  localparam logic [CW_LEN_W-1:0] CW_K1024_1_2 = 14'd2048;
  localparam logic [CW_LEN_W-1:0] CW_K1024_2_3 = 14'd1536;
  localparam logic [CW_LEN_W-1:0] CW_K1024_4_5 = 14'd1280;
  localparam logic [CW_LEN_W-1:0] CW_K4096_1_2 = 14'd8192;
  localparam logic [CW_LEN_W-1:0] CW_K4096_2_3 = 14'd6144;
  localparam logic [CW_LEN_W-1:0] CW_K4096_4_5 = 14'd5120;

  typedef enum logic [1:0] {
    SLOT_FREE     = 2'd0,
    SLOT_LOADING  = 2'd1,
    SLOT_DECODING = 2'd2,
    SLOT_HOLD     = 2'd3
  } slot_st_e;

  typedef enum logic [1:0] {
    L_IDLE   = 2'd0,
    L_ACTIVE = 2'd1,
    L_DROP   = 2'd2
  } load_st_e;

  // Unknown rate codes fall back to the rate 1/2 length.
  function automatic logic [CW_LEN_W-1:0] cw_len(
    input logic       len4096,
    input logic [1:0] rate
  );
    logic [CW_LEN_W-1:0] n;
    case (rate)
      LDPC_RATE_2_3: n = len4096 ? CW_K4096_2_3 : CW_K1024_2_3;
      LDPC_RATE_4_5: n = len4096 ? CW_K4096_4_5 : CW_K1024_4_5;
      default:       n = len4096 ? CW_K4096_1_2 : CW_K1024_1_2;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ldpc_retire_fifo.sv
// In-order retire queue of decoder slot IDs.
// Depth equals the decoder count, so it can never overflow.
module ldpc_retire_fifo
  import ldpc_decoder_scheduler_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= nxt(wr_q);
      end
      if (pop_i) begin
        rd_q <= nxt(rd_q);
      end
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/ldpc_decoder_scheduler.sv
// Assigns framed LDPC codewords to free decoders, retires in order.
// Optional statistics counters: define LDPC_SCHED_STATS_EN.
module ldpc_decoder_scheduler
  import ldpc_decoder_scheduler_pkg::*;
#(
  parameter int NUM_DEC = 2,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ldpcRun,
  input  logic               clkEn,
  input  logic               dataBitIn,
  input  logic               codewordEn,
  input  logic               codeLength4096,
  input  logic [1:0]         codeRate,
  output logic               ldpcReady,
  output logic [NUM_DEC-1:0] decStart,
  output logic [NUM_DEC-1:0] decLoadEn,
  output logic               decLoadBit,
  output logic               decLastBit,
  output logic [NUM_DEC-1:0] decAbort,
  input  logic [NUM_DEC-1:0] decDone,
  output logic               outValid,
  output logic [ID_W-1:0]    outSel,
  input  logic               outReady,
  output logic               overrun
`ifdef LDPC_SCHED_STATS_EN
  ,
  output logic [15:0]        cwDoneCount,
  output logic [15:0]        cwDropCount,
  output logic [15:0]        cwAbortCount
`endif
);

  // Counter holds bits remaining after the current one (max N-2).
  localparam int CNT_W = CW_LEN_W - 1;

  logic clr;

  load_st_e         lst_q;
  slot_st_e         slot_q [NUM_DEC];
  slot_st_e         slot_d [NUM_DEC];
  logic             prevEn_q;
  logic [CNT_W-1:0] bitCnt_q;
  logic [ID_W-1:0]  sel_q;

  logic               ldpcReady_q;
  logic [NUM_DEC-1:0] decStart_q;
  logic [NUM_DEC-1:0] decLoadEn_q;
  logic               decLoadBit_q;
  logic               decLastBit_q;
  logic [NUM_DEC-1:0] decAbort_q;
  logic               overrun_q;

  logic            anyFree;
  logic [ID_W-1:0] freeSel;
  logic            headHold;
  logic [ID_W-1:0] headId;
  logic            fifoEmpty;

  logic startEv;
  logic doStart;
  logic doDrop;
  logic doLoad;
  logic doLast;
  logic doAbort;
  logic doPop;

  function automatic logic [NUM_DEC-1:0] oh(
    input logic [ID_W-1:0] s
  );
    logic [NUM_DEC-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_DEC; i++) begin
      if (ID_W'(i) == s) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign clr = reset | ~ldpcRun;

  // Lowest-index FREE slot, from registered state only.
  always_comb begin
    anyFree = 1'b0;
    freeSel = '0;
    for (int i = NUM_DEC - 1; i >= 0; i--) begin
      if (slot_q[i] == SLOT_FREE) begin
        anyFree = 1'b1;
        freeSel = ID_W'(i);
      end
    end
  end

  // Whether the head-of-line slot has a finished result.
  always_comb begin
    headHold = 1'b0;
    for (int i = 0; i < NUM_DEC; i++) begin
      if (ID_W'(i) == headId) begin
        headHold = (slot_q[i] == SLOT_HOLD);
      end
    end
  end

  // Load-path events for this cycle.
  always_comb begin
    startEv = clkEn & codewordEn & ~prevEn_q;
    doStart = (lst_q == L_IDLE) & startEv & anyFree;
    doDrop  = (lst_q == L_IDLE) & startEv & ~anyFree;
    doLoad  = (lst_q == L_ACTIVE) & clkEn & codewordEn;
    doLast  = doLoad & (bitCnt_q == '0);
    doAbort = (lst_q == L_ACTIVE) & clkEn & ~codewordEn;
  end

  assign outValid = ~clr & ~fifoEmpty & headHold;
  assign outSel   = headId;
  assign doPop    = outValid & outReady;

  // Slot next-state; the writers never target the same slot at once.
  always_comb begin
    for (int i = 0; i < NUM_DEC; i++) begin
      slot_d[i] = slot_q[i];
      if (clkEn && decDone[i] && slot_q[i] == SLOT_DECODING)
        slot_d[i] = SLOT_HOLD;
      if (doPop && headId == ID_W'(i))
        slot_d[i] = SLOT_FREE;
      if (doStart && freeSel == ID_W'(i))
        slot_d[i] = SLOT_LOADING;
      if (doLast && sel_q == ID_W'(i))
        slot_d[i] = SLOT_DECODING;
      if (doAbort && sel_q == ID_W'(i))
        slot_d[i] = SLOT_FREE;
    end
  end

  // Slot state registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NUM_DEC; i++) begin
        slot_q[i] <= SLOT_FREE;
      end
    end else begin
      for (int i = 0; i < NUM_DEC; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  // Load FSM with registered decoder-side outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      lst_q        <= L_IDLE;
      prevEn_q     <= 1'b0;
      bitCnt_q     <= '0;
      sel_q        <= '0;
      ldpcReady_q  <= 1'b0;
      decStart_q   <= '0;
      decLoadEn_q  <= '0;
      decLoadBit_q <= 1'b0;
      decLastBit_q <= 1'b0;
      decAbort_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      decStart_q   <= '0;
      decLoadEn_q  <= '0;
      decLoadBit_q <= 1'b0;
      decLastBit_q <= 1'b0;
      decAbort_q   <= '0;
      ldpcReady_q  <= anyFree;
      if (clkEn) prevEn_q <= codewordEn;
      unique case (lst_q)
        L_IDLE: begin
          if (doStart) begin
            sel_q        <= freeSel;
            bitCnt_q     <= CNT_W'(
              cw_len(codeLength4096, codeRate) - 14'd2);
            decStart_q   <= oh(freeSel);
            decLoadEn_q  <= oh(freeSel);
            decLoadBit_q <= dataBitIn;
            lst_q        <= L_ACTIVE;
          end else if (doDrop) begin
            overrun_q <= 1'b1;
            lst_q     <= L_DROP;
          end
        end
        L_ACTIVE: begin
          if (doAbort) begin
            decAbort_q <= oh(sel_q);
            lst_q      <= L_IDLE;
          end else if (doLoad) begin
            decLoadEn_q  <= oh(sel_q);
            decLoadBit_q <= dataBitIn;
            if (doLast) begin
              decLastBit_q <= 1'b1;
              lst_q        <= L_IDLE;
            end else begin
              bitCnt_q <= bitCnt_q - CNT_W'(1);
            end
          end
        end
        L_DROP: begin
          if (clkEn && !codewordEn) lst_q <= L_IDLE;
        end
        default: lst_q <= L_IDLE;
      endcase
    end
  end

  assign ldpcReady  = ldpcReady_q;
  assign decStart   = decStart_q;
  assign decLoadEn  = decLoadEn_q;
  assign decLoadBit = decLoadBit_q;
  assign decLastBit = decLastBit_q;
  assign decAbort   = decAbort_q;
  assign overrun    = overrun_q;

  ldpc_retire_fifo #(
    .DEPTH (NUM_DEC),
    .W     (ID_W)
  ) u_fifo (
    .clk     (clk),
    .clr_i   (clr),
    .push_i  (doLast),
    .din_i   (sel_q),
    .pop_i   (doPop),
    .head_o  (headId),
    .empty_o (fifoEmpty)
  );

`ifdef LDPC_SCHED_STATS_EN
  logic [15:0] cwDone_q;
  logic [15:0] cwDrop_q;
  logic [15:0] cwAbort_q;

  // Saturating retire/drop/abort counters.
  always_ff @(posedge clk) begin
    if (clr) begin
      cwDone_q  <= '0;
      cwDrop_q  <= '0;
      cwAbort_q <= '0;
    end else begin
      if (doPop && cwDone_q != 16'hFFFF)
        cwDone_q <= cwDone_q + 16'd1;
      if (doDrop && cwDrop_q != 16'hFFFF)
        cwDrop_q <= cwDrop_q + 16'd1;
      if (doAbort && cwAbort_q != 16'hFFFF)
        cwAbort_q <= cwAbort_q + 16'd1;
    end
  end

  assign cwDoneCount  = cwDone_q;
  assign cwDropCount  = cwDrop_q;
  assign cwAbortCount = cwAbort_q;
`endif

endmodule

// File: tb/tb_ldpc_decoder_scheduler.sv
// Bench for ldpc_decoder_scheduler.
// Stimulus queues expected decoder events; a monitor checks them.
module tb_ldpc_decoder_scheduler;

  localparam int NUM_DEC = 2;
  localparam int ID_W    = 2;

  localparam int EV_START  = 0;
  localparam int EV_LAST   = 1;
  localparam int EV_ABORT  = 2;
  localparam int EV_RETIRE = 3;

  typedef struct {
    int kind;
    int idx;
    int cnt;
    int par;
  } ev_t;

  logic               clk;
  logic               reset;
  logic               ldpcRun;
  logic               clkEn;
  logic               dataBitIn;
  logic               codewordEn;
  logic               codeLength4096;
  logic [1:0]         codeRate;
  logic               ldpcReady;
  logic [NUM_DEC-1:0] decStart;
  logic [NUM_DEC-1:0] decLoadEn;
  logic               decLoadBit;
  logic               decLastBit;
  logic [NUM_DEC-1:0] decAbort;
  logic [NUM_DEC-1:0] decDone;
  logic               outValid;
  logic [ID_W-1:0]    outSel;
  logic               outReady;
  logic               overrun;
`ifdef LDPC_SCHED_STATS_EN
  logic [15:0]        cwDoneCount;
  logic [15:0]        cwDropCount;
  logic [15:0]        cwAbortCount;
`endif

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;
  ev_t exp_q[$];
  int ld_cnt [NUM_DEC];
  int ld_par [NUM_DEC];
  int ms;
  int s0;

  ldpc_decoder_scheduler #(
    .NUM_DEC (NUM_DEC),
    .ID_W    (ID_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ldpcRun        (ldpcRun),
    .clkEn          (clkEn),
    .dataBitIn      (dataBitIn),
    .codewordEn     (codewordEn),
    .codeLength4096 (codeLength4096),
    .codeRate       (codeRate),
    .ldpcReady      (ldpcReady),
    .decStart       (decStart),
    .decLoadEn      (decLoadEn),
    .decLoadBit     (decLoadBit),
    .decLastBit     (decLastBit),
    .decAbort       (decAbort),
    .decDone        (decDone),
    .outValid       (outValid),
    .outSel         (outSel),
    .outReady       (outReady),
    .overrun        (overrun)
`ifdef LDPC_SCHED_STATS_EN
    ,
    .cwDoneCount    (cwDoneCount),
    .cwDropCount    (cwDropCount),
    .cwAbortCount   (cwAbortCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ev_t mk_ev(int k, int i, int c, int p);
    ev_t e;
    e.kind = k;
    e.idx  = i;
    e.cnt  = c;
    e.par  = p;
    return e;
  endfunction

  function automatic int oh2i(logic [NUM_DEC-1:0] v);
    int r;
    r = -1;
    if ($countones(v) == 1) begin
      for (int i = 0; i < NUM_DEC; i++) begin
        if (v[i]) r = i;
      end
    end
    return r;
  endfunction

  function automatic int bitpat(int b, int seed);
    logic [31:0] v;
    v = b ^ (b >> 3) ^ seed;
    return int'(v[0]);
  endfunction

  task automatic got(int k, int i, int c, int p);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL event: unexpected kind=%0d idx=%0d cnt=%0d",
               k, i, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.idx != i || e.cnt != c || e.par != p) begin
        failures++;
        $display("FAIL event: got k%0d i%0d c%0d p%0d need k%0d i%0d c%0d p%0d",
                 k, i, c, p, e.kind, e.idx, e.cnt, e.par);
      end
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d need %0d", nm, act, exp);
    end
  endtask

  // Monitor: turns DUT output activity into events.
  always @(negedge clk) begin
    if (reset || !ldpcRun) begin
      for (int i = 0; i < NUM_DEC; i++) begin
        ld_cnt[i] = 0;
        ld_par[i] = 0;
      end
    end else begin
      if (decStart != '0) begin
        ms = oh2i(decStart);
        if (ms >= 0) begin
          ld_cnt[ms] = 0;
          ld_par[ms] = 0;
        end
        got(EV_START, ms, 0, 0);
      end
      for (int i = 0; i < NUM_DEC; i++) begin
        if (decLoadEn[i]) begin
          ld_cnt[i] = ld_cnt[i] + 1;
          ld_par[i] = ld_par[i] ^ int'(decLoadBit);
          strobes++;
        end
      end
      if (decLastBit) begin
        ms = oh2i(decLoadEn);
        if (ms >= 0) got(EV_LAST, ms, ld_cnt[ms], ld_par[ms]);
        else got(EV_LAST, -1, -1, 0);
      end
      if (decAbort != '0) begin
        ms = oh2i(decAbort);
        if (ms >= 0) got(EV_ABORT, ms, ld_cnt[ms], ld_par[ms]);
        else got(EV_ABORT, -1, -1, 0);
      end
      if (outValid && outReady) begin
        got(EV_RETIRE, int'(outSel), 0, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cw(input bit l4k, input logic [1:0] rate,
                         input int nbits, input int p,
                         input int slot, input bit full,
                         input int seed);
    int par;
    par = 0;
    for (int b = 0; b < nbits; b++) par = par ^ bitpat(b, seed);
    if (slot >= 0) begin
      exp_q.push_back(mk_ev(EV_START, slot, 0, 0));
      exp_q.push_back(mk_ev(full ? EV_LAST : EV_ABORT,
                            slot, nbits, par));
    end
    codeLength4096 = l4k;
    codeRate       = rate;
    codewordEn     = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      dataBitIn = bitpat(b, seed) != 0;
      clkEn     = 1'b1;
      tick();
      clkEn = 1'b0;
      repeat (p - 1) tick();
    end
    codewordEn = 1'b0;
    dataBitIn  = 1'b0;
    repeat (3) begin
      clkEn = 1'b1;
      tick();
      clkEn = 1'b0;
      repeat (p - 1) tick();
    end
  endtask

  task automatic finish_dec(input logic [NUM_DEC-1:0] d);
    decDone = d;
    clkEn   = 1'b1;
    tick();
    tick();
    clkEn = 1'b0;
  endtask

  task automatic retire(input int a, input int b);
    int n;
    n = 1;
    exp_q.push_back(mk_ev(EV_RETIRE, a, 0, 0));
    if (b >= 0) begin
      exp_q.push_back(mk_ev(EV_RETIRE, b, 0, 0));
      n = 2;
    end
    outReady = 1'b1;
    repeat (n) tick();
    outReady = 1'b0;
    tick();
  endtask

  task automatic run_clear();
    ldpcRun = 1'b0;
    tick();
    ldpcRun = 1'b1;
    tick();
  endtask

  initial begin
    reset          = 1'b1;
    ldpcRun        = 1'b1;
    clkEn          = 1'b0;
    dataBitIn      = 1'b0;
    codewordEn     = 1'b0;
    codeLength4096 = 1'b0;
    codeRate       = 2'd0;
    decDone        = '0;
    outReady       = 1'b0;
    repeat (3) tick();
    chk("rst_ready", int'(ldpcReady), 0);
    chk("rst_valid", int'(outValid), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", int'(ldpcReady), 1);

    // k1024 1/2, single codeword into slot 0.
    s0 = strobes;
    send_cw(1'b0, 2'd0, 2048, 1, 0, 1'b1, 0);
    chk("t1_strobes", strobes - s0, 2048);
    chk("t1_valid_pre", int'(outValid), 0);
    finish_dec(2'b01);
    chk("t1_valid", int'(outValid), 1);
    chk("t1_sel", int'(outSel), 0);
    retire(0, -1);
    decDone = '0;
    chk("t1_valid_post", int'(outValid), 0);

    // Three k1024 4/5 codewords, decoders busy.
    send_cw(1'b0, 2'd2, 1280, 1, 0, 1'b1, 1);
    chk("t2_ready_a", int'(ldpcReady), 1);
    send_cw(1'b0, 2'd2, 1280, 1, 1, 1'b1, 2);
    chk("t2_ready_b", int'(ldpcReady), 0);
    chk("t2_overrun_b", int'(overrun), 0);
    s0 = strobes;
    send_cw(1'b0, 2'd2, 1280, 1, -1, 1'b0, 3);
    chk("t2_drop_strobes", strobes - s0, 0);
    chk("t2_overrun", int'(overrun), 1);
    finish_dec(2'b11);
    retire(0, 1);
    decDone = '0;
    run_clear();
    chk("t2_overrun_clr", int'(overrun), 0);

    // k4096 2/3 aborted after 700 bits.
    send_cw(1'b1, 2'd1, 700, 1, 0, 1'b0, 4);
    chk("t3_valid", int'(outValid), 0);
    chk("t3_ready", int'(ldpcReady), 1);

    // Decoder 1 finishes first; retire order stays 0 then 1.
    send_cw(1'b0, 2'd1, 1536, 1, 0, 1'b1, 5);
    send_cw(1'b0, 2'd1, 1536, 1, 1, 1'b1, 6);
    finish_dec(2'b10);
    chk("t4_valid_hol", int'(outValid), 0);
    finish_dec(2'b11);
    chk("t4_valid", int'(outValid), 1);
    chk("t4_sel", int'(outSel), 0);
    retire(0, 1);
    decDone = '0;

    // Retire and start collide; freed slot not yet eligible.
    send_cw(1'b0, 2'd3, 2048, 1, 0, 1'b1, 7);
    send_cw(1'b0, 2'd2, 1280, 1, 1, 1'b1, 8);
    finish_dec(2'b01);
    chk("t5_valid", int'(outValid), 1);
    chk("t5_ready", int'(ldpcReady), 0);
    s0 = strobes;
    exp_q.push_back(mk_ev(EV_RETIRE, 0, 0, 0));
    codewordEn = 1'b1;
    dataBitIn  = 1'b1;
    clkEn      = 1'b1;
    outReady   = 1'b1;
    tick();
    outReady = 1'b0;
    repeat (49) tick();
    codewordEn = 1'b0;
    repeat (3) tick();
    clkEn = 1'b0;
    chk("t5_overrun", int'(overrun), 1);
    chk("t5_strobes", strobes - s0, 0);
    chk("t5_ready_after", int'(ldpcReady), 1);
    finish_dec(2'b10);
    retire(1, -1);
    decDone = '0;
    run_clear();

    // clkEn 1-in-4, reset mid-load, reload from bit 0.
    exp_q.push_back(mk_ev(EV_START, 0, 0, 0));
    codeLength4096 = 1'b0;
    codeRate       = 2'd0;
    codewordEn     = 1'b1;
    for (int b = 0; b < 100; b++) begin
      dataBitIn = 1'b1;
      clkEn     = 1'b1;
      tick();
      clkEn = 1'b0;
      repeat (3) tick();
    end
    codewordEn = 1'b0;
    reset      = 1'b1;
    tick();
    chk("t6_rst_outs",
        int'({ldpcReady, decStart, decLoadEn, decLoadBit,
              decLastBit, decAbort, outValid, outSel, overrun}), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_ready", int'(ldpcReady), 1);
    s0 = strobes;
    send_cw(1'b0, 2'd0, 2048, 4, 0, 1'b1, 9);
    chk("t6_strobes", strobes - s0, 2048);
    finish_dec(2'b01);
    retire(0, -1);
    decDone = '0;

    // k4096 4/5 and 1/2 lengths.
    send_cw(1'b1, 2'd2, 5120, 1, 0, 1'b1, 10);
    send_cw(1'b1, 2'd0, 8192, 1, 1, 1'b1, 11);
    finish_dec(2'b11);
    retire(0, 1);
    decDone = '0;
    tick();
    chk("end_valid", int'(outValid), 0);
    chk("end_ready", int'(ldpcReady), 1);
    chk("end_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
